debounce_multi: RTL and testbench

- Parametrised successor of the single-input button debouncer: debounces N independent asynchronous inputs (buttons/switches) in one block.
- Per channel it provides a 2-flop synchroniser, a counter-based stability filter of configurable length, one-cycle rise/fall pulses and long-press ("held") detection.
- A shared sample prescaler lets slow mechanical inputs be filtered without wide counters.
- Sits between board pins and the game/control FSMs, replacing per-button debounce instances.

---
 rtl/debounce_pkg.sv | 12 +
 rtl/debounce_channel.sv | 93 +++++++++
 rtl/debounce_multi.sv | 61 ++++++
 tb/tb_debounce_multi.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and width helper for the multi-channel debouncer.
package debounce_pkg;

  localparam int DEB_STABLE_CNT = 10;
  localparam int DEB_SAMPLE_DIV = 1;

  // Counter width for a value, never below one bit.
  function automatic int width_of(input int value);
    return (value < 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: 2-flop synchroniser, tick-driven stability filter,
// rise/fall pulses and optional long-press detection.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CNT = DEB_STABLE_CNT,
  parameter int HOLD_CNT   = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall,
  output logic held,
  output logic held_pulse
);

  localparam int CW = width_of(STABLE_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

  logic          s0;
  logic          s1;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0   <= 1'b0;
      s1   <= 1'b0;
      cnt  <= '0;
      out  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s0   <= in;
      s1   <= s0;
      rise <= 1'b0;
      fall <= 1'b0;
      if (tick) begin
        // Any matching sample restarts qualification.
        if (s1 == out) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          out  <= s1;
          cnt  <= '0;
          rise <= s1;
          fall <= ~s1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  generate
    if (HOLD_CNT > 0) begin : g_hold
      localparam int HW = width_of(HOLD_CNT + 1);
      localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CNT);
      localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CNT - 1);

      logic [HW-1:0] hcnt;
      logic          falling;

      assign falling = tick && out && !s1 && (cnt == CNT_LAST);

      always_ff @(posedge clk) begin
        if (rst) begin
          hcnt       <= '0;
          held       <= 1'b0;
          held_pulse <= 1'b0;
        end else begin
          held_pulse <= 1'b0;
          // The release edge clears hold state together with the fall pulse.
          if (falling) begin
            hcnt <= '0;
            held <= 1'b0;
          end else if (tick && out && (hcnt != HOLD_MAX)) begin
            hcnt <= hcnt + 1'b1;
            if (hcnt == HOLD_LAST) begin
              held       <= 1'b1;
              held_pulse <= 1'b1;
            end
          end
        end
      end
    end else begin : g_no_hold
      assign held       = 1'b0;
      assign held_pulse = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/debounce_multi.sv
// N-channel debouncer: shared sample prescaler feeding independent
// debounce_channel lanes.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int N          = 4,
  parameter int SAMPLE_DIV = DEB_SAMPLE_DIV,
  parameter int STABLE_CNT = DEB_STABLE_CNT,
  parameter int HOLD_CNT   = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  output logic [N-1:0] out,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] held,
  output logic [N-1:0] held_pulse
);

  logic tick;

  generate
    if (SAMPLE_DIV > 1) begin : g_presc
      localparam int PW = width_of(SAMPLE_DIV);
      localparam logic [PW-1:0] P_LAST = PW'(SAMPLE_DIV - 1);

      logic [PW-1:0] pcnt;

      always_ff @(posedge clk) begin
        if (rst || (pcnt == P_LAST)) begin
          pcnt <= '0;
        end else begin
          pcnt <= pcnt + 1'b1;
        end
      end

      assign tick = (pcnt == P_LAST);
    end else begin : g_no_presc
      assign tick = 1'b1;
    end
  endgenerate

  for (genvar i = 0; i < N; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CNT (STABLE_CNT),
      .HOLD_CNT   (HOLD_CNT)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .in         (in[i]),
      .out        (out[i]),
      .rise       (rise[i]),
      .fall       (fall[i]),
      .held       (held[i]),
      .held_pulse (held_pulse[i])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench: two debounce_multi configurations against a
// behavioural model, plus directed latency/boundary checks.
module tb_debounce_multi;

  localparam int NCH = 4;
  localparam int S_CFG [2]  = '{10, 3};
  localparam int SD_CFG [2] = '{1, 4};
  localparam int H_CFG [2]  = '{20, 0};

  localparam int SEL_OUT = 0, SEL_RISE = 1, SEL_FALL = 2, SEL_HELD = 3, SEL_HP = 4;

  logic clk, rst;
  logic [3:0] in_a, out_a, rise_a, fall_a, held_a, hp_a;
  logic [3:0] in_b, out_b, rise_b, fall_b, held_b, hp_b;

  int checks = 0;
  int errors = 0;

  debounce_multi #(.N(4), .SAMPLE_DIV(1), .STABLE_CNT(10), .HOLD_CNT(20)) dut_a (
    .clk(clk), .rst(rst), .in(in_a), .out(out_a), .rise(rise_a),
    .fall(fall_a), .held(held_a), .held_pulse(hp_a)
  );

  debounce_multi #(.N(4), .SAMPLE_DIV(4), .STABLE_CNT(3), .HOLD_CNT(0)) dut_b (
    .clk(clk), .rst(rst), .in(in_b), .out(out_b), .rise(rise_b),
    .fall(fall_b), .held(held_b), .held_pulse(hp_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] get_vec(input int d, input int sel);
    case (sel)
      SEL_OUT:  return d == 0 ? out_a  : out_b;
      SEL_RISE: return d == 0 ? rise_a : rise_b;
      SEL_FALL: return d == 0 ? fall_a : fall_b;
      SEL_HELD: return d == 0 ? held_a : held_b;
      default:  return d == 0 ? hp_a   : hp_b;
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  // Each channel's output follows the synchronised input once it has
  // disagreed with the output on S consecutive sample ticks.
  bit m_valid = 1'b0;
  bit ms0 [2][NCH], ms1 [2][NCH];
  bit mo [2][NCH], mr [2][NCH], mf [2][NCH], mh [2][NCH], mhp [2][NCH];
  int streak [2][NCH], hticks [2][NCH];
  int nedge [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit tk;
      logic [3:0] iv;
      iv = (d == 0) ? in_a : in_b;
      tk = (nedge[d] % SD_CFG[d]) == SD_CFG[d] - 1;
      for (int c = 0; c < NCH; c++) begin
        if (rst) begin
          ms0[d][c] = 0; ms1[d][c] = 0; mo[d][c] = 0; mr[d][c] = 0;
          mf[d][c] = 0; mh[d][c] = 0; mhp[d][c] = 0;
          streak[d][c] = 0; hticks[d][c] = 0;
        end else begin
          bit was_high;
          mr[d][c] = 0; mf[d][c] = 0; mhp[d][c] = 0;
          if (tk) begin
            was_high = mo[d][c];
            streak[d][c] = (ms1[d][c] != mo[d][c]) ? streak[d][c] + 1 : 0;
            if (streak[d][c] == S_CFG[d]) begin
              mo[d][c] = ms1[d][c];
              streak[d][c] = 0;
              if (mo[d][c]) mr[d][c] = 1; else mf[d][c] = 1;
            end
            if (H_CFG[d] > 0) begin
              if (mf[d][c]) begin
                hticks[d][c] = 0;
                mh[d][c] = 0;
              end else if (was_high && hticks[d][c] < H_CFG[d]) begin
                hticks[d][c]++;
                if (hticks[d][c] == H_CFG[d]) begin
                  mh[d][c] = 1;
                  mhp[d][c] = 1;
                end
              end
            end
          end
          ms1[d][c] = ms0[d][c];
          ms0[d][c] = iv[c];
        end
      end
      nedge[d] = rst ? 0 : nedge[d] + 1;
    end
    if (rst) m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      for (int d = 0; d < 2; d++) begin
        logic [3:0] eo, er, ef, eh, ep;
        for (int c = 0; c < NCH; c++) begin
          eo[c] = mo[d][c]; er[c] = mr[d][c]; ef[c] = mf[d][c];
          eh[c] = mh[d][c]; ep[c] = mhp[d][c];
        end
        chk(d == 0 ? "model_out_a"  : "model_out_b",  get_vec(d, SEL_OUT),  eo);
        chk(d == 0 ? "model_rise_a" : "model_rise_b", get_vec(d, SEL_RISE), er);
        chk(d == 0 ? "model_fall_a" : "model_fall_b", get_vec(d, SEL_FALL), ef);
        chk(d == 0 ? "model_held_a" : "model_held_b", get_vec(d, SEL_HELD), eh);
        chk(d == 0 ? "model_hp_a"   : "model_hp_b",   get_vec(d, SEL_HP),   ep);
      end
    end
  end

  // Count negedges until the selected bit reaches val (edge 1 = first capture).
  task automatic measure(input int d, input int sel, input int ch, input bit val,
                         input int budget, output int n);
    logic [3:0] v;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      v = get_vec(d, sel);
    end while (v[ch] !== val && n <= budget);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int n, cnt;
    logic prev_held;
    rst = 1'b1; in_a = 4'hf; in_b = 4'hf;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_a", out_a, 0);
    chk("rst_rise_a", rise_a, 0);
    chk("rst_held_a", held_a, 0);
    chk("rst_out_b", out_b, 0);
    repeat (10) @(negedge clk);
    chk("rst_out_a_e11", out_a, 4'h0);
    @(negedge clk);
    chk("rst_out_a_e12", out_a, 4'hf);
    chk("rst_rise_a_e12", rise_a, 4'hf);
    chk("rst_out_b_e12", out_b, 4'hf);

    in_a = 4'h0; in_b = 4'h0;
    repeat (30) @(negedge clk);

    // clean press on channel 0
    in_a[0] = 1'b1;
    measure(0, SEL_OUT, 0, 1'b1, 40, n);
    chk("press_latency", n, 12);
    chk("press_rise", rise_a, 4'h1);
    chk("press_fall", fall_a, 4'h0);
    @(negedge clk);
    chk("press_rise_once", rise_a[0], 0);

    // bouncing input: only the final stable level may pass
    in_a[0] = 1'b0;
    repeat (30) @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      in_a[0] = ((i / 3) % 2) == 0;
      @(negedge clk);
      cnt += int'(rise_a[0]);
    end
    chk("bounce_no_rise", cnt, 0);
    in_a[0] = 1'b1;
    measure(0, SEL_OUT, 0, 1'b1, 40, n);
    chk("bounce_latency", n, 12);
    cnt = int'(rise_a[0]);
    repeat (5) begin
      @(negedge clk);
      cnt += int'(rise_a[0]);
    end
    chk("bounce_rise_count", cnt, 1);

    // long press on channel 1
    in_a[1] = 1'b1;
    measure(0, SEL_OUT, 1, 1'b1, 40, n);
    chk("hold_press_latency", n, 12);
    n = 0; cnt = 0;
    while (held_a[1] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      cnt += int'(hp_a[1]);
    end
    chk("hold_latency", n, 20);
    repeat (10) begin
      @(negedge clk);
      cnt += int'(hp_a[1]);
    end
    chk("hold_pulse_count", cnt, 1);
    in_a[1] = 1'b0;
    n = 0;
    do begin
      prev_held = held_a[1];
      @(negedge clk);
      n++;
    end while (fall_a[1] !== 1'b1 && n <= 40);
    chk("release_latency", n, 12);
    chk("release_held_before", prev_held, 1);
    chk("release_held_with_fall", held_a[1], 0);

    cnt = 0;
    in_a[1] = 1'b1;
    repeat (15) begin
      @(negedge clk);
      cnt += int'(hp_a[1]);
    end
    in_a[1] = 1'b0;
    repeat (40) begin
      @(negedge clk);
      cnt += int'(hp_a[1]);
    end
    chk("short_repress_no_held", cnt, 0);

    // simultaneous release on channels 0 and 2
    in_a[2] = 1'b1;
    repeat (20) @(negedge clk);
    in_a[0] = 1'b0; in_a[2] = 1'b0;
    measure(0, SEL_FALL, 0, 1'b1, 40, n);
    chk("multi_fall_latency", n, 12);
    chk("multi_fall_both", fall_a, 4'h5);

    // reset while channel 3 is mid-qualification (count at 7)
    in_a[3] = 1'b1;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    measure(0, SEL_OUT, 3, 1'b1, 40, n);
    chk("mid_reset_full_requal", n, 12);

    // prescaled instance: press latency window and a short glitch
    repeat (10) @(negedge clk);
    in_b[0] = 1'b1;
    measure(1, SEL_OUT, 0, 1'b1, 40, n);
    chk("presc_latency_window", int'(n >= 11 && n <= 14), 1);
    cnt = 0;
    in_b[1] = 1'b1;
    repeat (8) begin
      @(negedge clk);
      cnt += int'(rise_b[1]);
    end
    in_b[1] = 1'b0;
    repeat (30) begin
      @(negedge clk);
      cnt += int'(rise_b[1]);
    end
    chk("presc_glitch_rejected", cnt, 0);

    // random traffic on both instances, one reset in the middle
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 15) == 0) in_a[c] = ~in_a[c];
        if ($urandom_range(0, 39) == 0) in_b[c] = ~in_b[c];
      end
      rst = (cyc == 1500);
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
